jtcop_snd_mix: RTL
==================

// Module: jtcop_snd_mix
// PURPOSE
//  Downstream of the sound subsystem. Sums the four sound-board sources into one 16-bit signed
//  output: OPL FM, OPN FM, OPN PSG and upsampled OKI ADPCM.
//  Each source is scaled by an 8-bit gain. One time-shared multiplier does this in a short
//  multiply-accumulate sequence, once per output sample strobe.
//  The output saturates and feeds the jtframe audio output.
// PARAMETERS
//  ACC_W   26  accumulator width: 16b sample + 8b gain + 2b headroom for 4 channels
//  GAIN_FR 4   gain fraction bits; gain 8'h10 = unity
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   synchronous reset, active low
//  sample      in   1   output-rate strobe, one clk wide (~52-55 kHz)
//  opl_snd     in  16   signed OPL FM sample
//  opn_snd     in  16   signed OPN FM sample
//  psg_snd     in  10   unsigned PSG sum, midpoint 512
//  adpcm_snd   in  16   signed upsampled ADPCM sample
//  gain0..3    in   8   unsigned gains, GAIN_FR fraction bits; channel order OPL, OPN, PSG, ADPCM
//  snd         out 16   signed mixed sample
//  sample_out  out  1   one-clk pulse when snd updates
//  peak        out  1   clip indicator (see CONFIGURATION)
// BEHAVIOUR
//  Clock and reset: one clock (clk); rst_n is synchronous and active low.
//  Reset values: snd=0, sample_out=0, peak=0, FSM=IDLE, accumulator=0.
//  FSM: IDLE -> MAC0 -> MAC1 -> MAC2 -> MAC3 -> SAT -> IDLE, one clk per state.
//  IDLE, sample=1:
//    - latch all four inputs and all four gains into holding registers;
//    - clear the accumulator;
//    - go to MAC0.
//  Input or gain changes after the latch have no effect on the current sample.
//  MACn: acc <= acc + ch[n]*$signed({1'b0,gain[n]}).
//    - Product is 25b signed, sign-extended to ACC_W.
//  PSG conversion, before latching:
//    - ps = {~psg_snd[9], psg_snd[8:0]}, signed, so 512 maps to 0;
//    - then {ps, 6'd0} gives 16b scale.
//  SAT:
//    - r = acc >>> GAIN_FR (arithmetic shift);
//    - r > 32767 gives 16'h7FFF; r < -32768 gives 16'h8000; otherwise r[15:0];
//    - result registered into snd, with sample_out=1 in that same cycle.
//  Latency: sample strobe at cycle 0 gives snd/sample_out valid at cycle 6. snd holds until the next update.
//  Overlap: a sample strobe arriving while not in IDLE is dropped. No queuing, no restart.
//  Sample strobe in the same cycle SAT completes: dropped, because FSM is not IDLE in that cycle.
//  Reset mid-sequence: the sequence aborts, no sample_out, snd=0.
//  Zero gain on a channel: that channel contributes exactly 0.
// CONFIGURATION
//  JTCOP_MIX_PEAK_EN defined:
//    - peak goes high for 65536 clk after any SAT cycle that clipped;
//    - the 16b down-counter reloads on every further clip.
//  JTCOP_MIX_PEAK_EN undefined:
//    - peak tied to 0, no counter logic;
//    - saturation itself is unchanged.
// STRUCTURE
//  Shared package jtcop_mix_pkg holds:
//    - constants MIX_CH=4, ACC_W, GAIN_FR, GAIN_UNITY=8'h10;
//    - FSM state encoding: IDLE, MAC0-3, SAT;
//    - channel index constants CH_OPL, CH_OPN, CH_PSG, CH_ADPCM.
//  Sub-module jtcop_mix_sat: combinational shift plus clamp from ACC_W to 16b, with a clip flag output.
//  The clip flag drives the peak logic.
//  Everything else (FSM, holding registers, multiplier, accumulator) lives in jtcop_snd_mix.
// TESTING
//  1. Unity gains; opl=1000, opn=-300, psg=512, adpcm=50; sample pulse
//     -> snd=750 at cycle 6; sample_out high for exactly 1 clk.
//  2. All gains 8'h20, opl=opn=adpcm=20000
//     -> clamped snd=16'h7FFF; peak=1 when PEAK_EN; mirror case with -20000 gives 16'h8000.
//  3. psg=1023, other sources 0, gain2=8'h10 -> snd=511*64=32704;
//     psg=0 -> snd=-32768; psg=512 -> snd=0.
//  4. Second sample pulse at cycle 3 of a sequence -> ignored, a single sample_out.
//     Inputs changed at cycle 1 -> result uses values latched at cycle 0.
//  5. rst_n low at cycle 2 of a sequence -> no sample_out; snd=0.
//     Next sample after reset produces a correct result.
//  6. gain0=8'h08, opl=-1001, others 0 -> snd=-501 (arithmetic shift floors toward -inf).

Source files
------------

// File: rtl/jtcop_mix_pkg.sv
// jtcop_mix_pkg: shared constants, FSM encoding and channel indices for the sound mixer.
package jtcop_mix_pkg;

  localparam int MIX_CH  = 4;
  localparam int ACC_W   = 26;
  localparam int GAIN_FR = 4;
  localparam int SMP_W   = 16;
  localparam int PROD_W  = 25;
  localparam logic [7:0] GAIN_UNITY = 8'h10;

  localparam logic [1:0] CH_OPL   = 2'd0;
  localparam logic [1:0] CH_OPN   = 2'd1;
  localparam logic [1:0] CH_PSG   = 2'd2;
  localparam logic [1:0] CH_ADPCM = 2'd3;

  typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, MAC3, SAT} mix_state_t;

  typedef logic [MIX_CH-1:0][SMP_W-1:0] mix_smp_t;
  typedef logic [MIX_CH-1:0][7:0]       mix_gain_t;

  // Offset-binary PSG sum to signed 16b: flipping the MSB recentres 512 on zero.
  function automatic logic [SMP_W-1:0] psg_to_s16(input logic [9:0] psg);
    return {~psg[9], psg[8:0], 6'd0};
  endfunction

endpackage

// File: rtl/jtcop_mix_sat.sv
// jtcop_mix_sat: drops the gain fraction bits from the accumulator and clamps to signed 16b.
// Purely combinational; clip flags any clamp.
module jtcop_mix_sat
  import jtcop_mix_pkg::*;
(
  input  logic [ACC_W-1:0] acc,
  output logic [15:0]      snd,
  output logic             clip
);

  localparam int R_W = ACC_W - GAIN_FR;
  localparam logic signed [R_W-1:0] S16_MAX = 32767;
  localparam logic signed [R_W-1:0] S16_MIN = -32768;

  logic signed [R_W-1:0] r;

  // Taking the upper bits is an arithmetic shift right by GAIN_FR (floors toward -inf).
  assign r = $signed(acc[ACC_W-1:GAIN_FR]);

  always_comb begin
    snd  = r[15:0];
    clip = 1'b0;
    if (r > S16_MAX) begin
      snd  = 16'h7FFF;
      clip = 1'b1;
    end else if (r < S16_MIN) begin
      snd  = 16'h8000;
      clip = 1'b1;
    end
  end

endmodule

// File: rtl/jtcop_snd_mix.sv
// jtcop_snd_mix: four-source gain mixer on one shared multiplier; optional clip indicator under JTCOP_MIX_PEAK_EN.
// Latency 6 clk from sample to sample_out; no backpressure, strobes arriving mid-sequence are dropped.
module jtcop_snd_mix
  import jtcop_mix_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample,
  input  logic [15:0] opl_snd,
  input  logic [15:0] opn_snd,
  input  logic [9:0]  psg_snd,
  input  logic [15:0] adpcm_snd,
  input  logic [7:0]  gain0,
  input  logic [7:0]  gain1,
  input  logic [7:0]  gain2,
  input  logic [7:0]  gain3,
  output logic [15:0] snd,
  output logic        sample_out,
  output logic        peak
);

  mix_state_t               st, st_nx;
  mix_smp_t                 ch_q;
  mix_gain_t                gain_q;
  logic [ACC_W-1:0]         acc;
  logic [1:0]               sel;
  logic                     mac_en;
  logic signed [PROD_W-1:0] prod;
  logic [15:0]              sat_snd;
  logic                     sat_clip;

  always_comb begin
    st_nx  = st;
    mac_en = 1'b0;
    sel    = CH_OPL;
    case (st)
      IDLE: if (sample) st_nx = MAC0;
      MAC0: begin mac_en = 1'b1; sel = CH_OPL;   st_nx = MAC1; end
      MAC1: begin mac_en = 1'b1; sel = CH_OPN;   st_nx = MAC2; end
      MAC2: begin mac_en = 1'b1; sel = CH_PSG;   st_nx = MAC3; end
      MAC3: begin mac_en = 1'b1; sel = CH_ADPCM; st_nx = SAT;  end
      SAT:  st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  // Gain is unsigned, so a zero sign bit keeps it positive in the signed product.
  assign prod = PROD_W'($signed(ch_q[sel])) * PROD_W'($signed({1'b0, gain_q[sel]}));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st         <= IDLE;
      ch_q       <= '0;
      gain_q     <= '0;
      acc        <= '0;
      snd        <= '0;
      sample_out <= 1'b0;
    end else begin
      st         <= st_nx;
      sample_out <= 1'b0;
      if (st == IDLE && sample) begin
        ch_q[CH_OPL]     <= opl_snd;
        ch_q[CH_OPN]     <= opn_snd;
        ch_q[CH_PSG]     <= psg_to_s16(psg_snd);
        ch_q[CH_ADPCM]   <= adpcm_snd;
        gain_q[CH_OPL]   <= gain0;
        gain_q[CH_OPN]   <= gain1;
        gain_q[CH_PSG]   <= gain2;
        gain_q[CH_ADPCM] <= gain3;
        acc              <= '0;
      end
      if (mac_en) acc <= $signed(acc) + ACC_W'(prod);
      if (st == SAT) begin
        snd        <= sat_snd;
        sample_out <= 1'b1;
      end
    end
  end

  jtcop_mix_sat u_sat (
    .acc  (acc),
    .snd  (sat_snd),
    .clip (sat_clip)
  );

`ifdef JTCOP_MIX_PEAK_EN
  logic [15:0] peak_cnt;

  // Holds peak for 65536 clk after the latest clipped sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      peak     <= 1'b0;
      peak_cnt <= '0;
    end else if (st == SAT && sat_clip) begin
      peak     <= 1'b1;
      peak_cnt <= 16'hFFFF;
    end else if (peak) begin
      if (peak_cnt == 16'd0) peak <= 1'b0;
      else                   peak_cnt <= peak_cnt - 16'd1;
    end
  end
`else
  logic unused_clip;
  assign unused_clip = sat_clip;
  assign peak        = 1'b0;
`endif

endmodule
